memtrace_lane_issuer: RTL and testbench

- Sits directly downstream of the SimMemTrace blackbox wrapper.
- Drives its cycle index and ready, and captures one multi-lane trace line at a time.
- Issues each valid lane as an independent memory request with per-lane valid/ready backpressure.
- Tracks outstanding responses and raises `finished` once the trace is exhausted and all traffic has drained.

---
 rtl/memtrace_lane_issuer_if.sv | 40 ++++
 rtl/memtrace_lane_issuer.sv | 168 ++++++++++++++++
 tb/tb_memtrace_lane_issuer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/memtrace_lane_issuer_if.sv
// Bundle of trace-source and per-lane memory request/response signals.
// The issuer uses the master view; the trace source and memory model use the slave view.
interface memtrace_lane_issuer_if #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int LOGSIZE_WIDTH = 8
);
    logic [63:0]                         trace_read_cycle;
    logic                                trace_read_ready;
    logic [NUM_LANES-1:0]                trace_read_valid;
    logic [DATA_WIDTH*NUM_LANES-1:0]     trace_read_address;
    logic [NUM_LANES-1:0]                trace_read_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0]  trace_read_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]     trace_read_data;
    logic                                trace_read_finished;

    logic [NUM_LANES-1:0]                req_valid;
    logic [NUM_LANES-1:0]                req_ready;
    logic [DATA_WIDTH*NUM_LANES-1:0]     req_address;
    logic [NUM_LANES-1:0]                req_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0]  req_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]     req_data;
    logic [NUM_LANES-1:0]                resp_valid;

    modport master (
        output trace_read_cycle, trace_read_ready,
        input  trace_read_valid, trace_read_address, trace_read_is_store,
        input  trace_read_size, trace_read_data, trace_read_finished,
        output req_valid, req_address, req_is_store, req_size, req_data,
        input  req_ready, resp_valid
    );

    modport slave (
        input  trace_read_cycle, trace_read_ready,
        output trace_read_valid, trace_read_address, trace_read_is_store,
        output trace_read_size, trace_read_data, trace_read_finished,
        input  req_valid, req_address, req_is_store, req_size, req_data,
        output req_ready, resp_valid
    );
endinterface

// File: rtl/memtrace_lane_issuer.sv
// Fetches one multi-lane trace line at a time, issues each valid lane as an
// independent request, counts outstanding traffic and flags completion.
module memtrace_lane_issuer #(
    parameter int NUM_LANES      = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int LOGSIZE_WIDTH  = 8,
    parameter int INFLIGHT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    memtrace_lane_issuer_if.master    bus,
    output logic [INFLIGHT_WIDTH-1:0] inflight,
    output logic                      finished
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_CAPTURE = 3'd1,
        S_ISSUE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Two spare bits so the add/subtract never wraps before saturation.
    localparam int CW = INFLIGHT_WIDTH + 2;
    localparam logic [CW-1:0] INFL_MAX = {2'b00, {INFLIGHT_WIDTH{1'b1}}};

    state_t                      state_q, state_d;
    logic [63:0]                 cycle_q, cycle_d;
    logic [NUM_LANES-1:0]        pending_q, pending_d;
    logic                        src_done_q, src_done_d;
    logic [INFLIGHT_WIDTH-1:0]   inflight_q, inflight_d;
    logic                        finished_q, finished_d;

    logic                        ready_int;
    logic                        capture_en;
    logic [NUM_LANES-1:0]        req_valid_int;
    logic [NUM_LANES-1:0]        fire;
    logic [CW-1:0]               infl_sum;
    logic [CW-1:0]               infl_net;
    logic [CW-1:0]               resp_cnt;
    logic                        underflow;

    function automatic logic [CW-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            acc = acc + {{(CW-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    assign capture_en    = (state_q == S_CAPTURE);
    assign req_valid_int = (state_q == S_ISSUE) ? pending_q : '0;
    assign fire          = req_valid_int & bus.req_ready;

    // Per-lane capture registers; fields are held while the lane is pending.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0]    addr_q;
            logic [DATA_WIDTH-1:0]    data_q;
            logic [LOGSIZE_WIDTH-1:0] size_q;
            logic                     store_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    addr_q  <= '0;
                    data_q  <= '0;
                    size_q  <= '0;
                    store_q <= 1'b0;
                end else if (capture_en) begin
                    addr_q  <= bus.trace_read_address[DATA_WIDTH*gi +: DATA_WIDTH];
                    data_q  <= bus.trace_read_data[DATA_WIDTH*gi +: DATA_WIDTH];
                    size_q  <= bus.trace_read_size[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH];
                    store_q <= bus.trace_read_is_store[gi];
                end
            end

            assign bus.req_address[DATA_WIDTH*gi +: DATA_WIDTH]     = addr_q;
            assign bus.req_data[DATA_WIDTH*gi +: DATA_WIDTH]        = data_q;
            assign bus.req_size[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH]  = size_q;
            assign bus.req_is_store[gi]                             = store_q;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            cycle_q    <= '0;
            pending_q  <= '0;
            src_done_q <= 1'b0;
            inflight_q <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            pending_q  <= pending_d;
            src_done_q <= src_done_d;
            inflight_q <= inflight_d;
            finished_q <= finished_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        pending_d  = pending_q;
        src_done_d = src_done_q;
        finished_d = finished_q;
        ready_int  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ready_int = 1'b1;
                cycle_d   = cycle_q + 64'd1;
                state_d   = S_CAPTURE;
            end
            S_CAPTURE: begin
                pending_d  = bus.trace_read_valid;
                src_done_d = src_done_q | bus.trace_read_finished;
                if (bus.trace_read_valid != '0) begin
                    state_d = S_ISSUE;
                end else if (bus.trace_read_finished) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                pending_d = pending_q & ~fire;
                if (pending_d == '0) begin
                    state_d = src_done_q ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    finished_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                finished_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Responses beyond what is outstanding are dropped rather than wrapping.
    always_comb begin
        infl_sum   = {2'b00, inflight_q} + popcount(fire);
        resp_cnt   = popcount(bus.resp_valid);
        underflow  = (infl_sum < resp_cnt);
        infl_net   = underflow ? '0 : (infl_sum - resp_cnt);
        inflight_d = (infl_net > INFL_MAX) ? {INFLIGHT_WIDTH{1'b1}}
                                           : infl_net[INFLIGHT_WIDTH-1:0];
    end

    assert property (@(posedge clock) disable iff (!reset) !underflow);

    // Ready is masked by reset so it is low for the whole time reset is held.
    assign bus.trace_read_ready = ready_int & reset;
    assign bus.trace_read_cycle = cycle_q;
    assign bus.req_valid        = req_valid_int;
    assign inflight             = inflight_q;
    assign finished             = finished_q;

endmodule

// File: tb/tb_memtrace_lane_issuer.sv
// Directed bench for memtrace_lane_issuer: a per-cycle vector table plus
// hand-written backpressure and mid-issue reset sequences.
module tb_memtrace_lane_issuer;

    localparam int NL = 4;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int IW = 16;

    logic          clock;
    logic          reset;
    logic [IW-1:0] inflight;
    logic          finished;

    memtrace_lane_issuer_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW)) bus ();

    memtrace_lane_issuer #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .INFLIGHT_WIDTH(IW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .inflight (inflight),
        .finished (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NL-1:0] tv;
        logic          tf;
        logic [NL-1:0] rr;
        logic [NL-1:0] rsp;
        logic          exp_rdy;
        int            exp_cyc;
        logic [NL-1:0] exp_req;
        int            exp_infl;
        logic          exp_fin;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic [NL-1:0] tv, input logic tf,
                                input logic [NL-1:0] rr, input logic [NL-1:0] rsp,
                                input logic rdy, input int cyc, input logic [NL-1:0] rq,
                                input int infl, input logic fin);
        vec_t v;
        v.tv = tv; v.tf = tf; v.rr = rr; v.rsp = rsp;
        v.exp_rdy = rdy; v.exp_cyc = cyc; v.exp_req = rq; v.exp_infl = infl; v.exp_fin = fin;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_addr(input logic [DW-1:0] base, input int g);
        return base + DW'(g * 16);
    endfunction

    task automatic set_line(input logic [NL-1:0] valid, input logic fin, input logic [DW-1:0] base);
        bus.trace_read_valid    = valid;
        bus.trace_read_finished = fin;
        for (int g = 0; g < NL; g++) begin
            bus.trace_read_address[DW*g +: DW] = lane_addr(base, g);
            bus.trace_read_data[DW*g +: DW]    = ~lane_addr(base, g);
            bus.trace_read_size[SW*g +: SW]    = SW'(g + 1);
            bus.trace_read_is_store[g]         = g[0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    localparam logic [DW-1:0] BASE_A = 64'hA5A5_0000_0000_1000;
    localparam logic [DW-1:0] BASE_B = 64'h0F0F_FFFF_0000_8000;

    initial begin
        reset          = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        set_line('0, 1'b0, BASE_A);

        //                tv      tf    rr       rsp      rdy cyc req      infl fin
        tbl[0]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0); // FETCH
        tbl[1]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0); // CAPTURE empty
        tbl[2]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0); // FETCH
        tbl[3]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 2, 4'b0000, 0, 0); // CAPTURE empty
        tbl[4]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0); // FETCH
        tbl[5]  = mk(4'b1111, 1'b0, 4'b0000, 4'b0000, 0, 3, 4'b0000, 0, 0); // CAPTURE 4 lanes
        tbl[6]  = mk(4'b0000, 1'b0, 4'b1111, 4'b0000, 0, 3, 4'b1111, 0, 0); // ISSUE all fire
        tbl[7]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0011, 1, 3, 4'b0000, 4, 0); // FETCH, 2 resp
        tbl[8]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0011, 0, 4, 4'b0000, 2, 0); // CAPTURE empty, 2 resp
        tbl[9]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 4, 4'b0000, 0, 0); // FETCH
        tbl[10] = mk(4'b0011, 1'b0, 4'b0000, 4'b0000, 0, 5, 4'b0000, 0, 0); // CAPTURE 2 lanes
        tbl[11] = mk(4'b0000, 1'b0, 4'b0010, 4'b0000, 0, 5, 4'b0011, 0, 0); // lane1 fires
        tbl[12] = mk(4'b0000, 1'b0, 4'b0001, 4'b0010, 0, 5, 4'b0001, 1, 0); // fire+resp nets 0
        tbl[13] = mk(4'b0000, 1'b0, 4'b0000, 4'b0001, 1, 5, 4'b0000, 1, 0); // FETCH, infl held
        tbl[14] = mk(4'b0101, 1'b1, 4'b0000, 4'b0000, 0, 6, 4'b0000, 0, 0); // CAPTURE last line
        tbl[15] = mk(4'b0000, 1'b0, 4'b1111, 4'b0000, 0, 6, 4'b0101, 0, 0); // ISSUE 2 fire
        tbl[16] = mk(4'b0000, 1'b0, 4'b1111, 4'b0000, 0, 6, 4'b0000, 2, 0); // DRAIN
        tbl[17] = mk(4'b0000, 1'b0, 4'b0000, 4'b0100, 0, 6, 4'b0000, 2, 0); // DRAIN resp
        tbl[18] = mk(4'b0000, 1'b0, 4'b0000, 4'b0001, 0, 6, 4'b0000, 1, 0); // DRAIN resp
        tbl[19] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 6, 4'b0000, 0, 0); // DRAIN empty
        tbl[20] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 6, 4'b0000, 0, 1); // DONE
        tbl[21] = mk(4'b1111, 1'b1, 4'b1111, 4'b0000, 0, 6, 4'b0000, 0, 1); // DONE ignores inputs

        #1;
        check("reset ready", 64'(bus.trace_read_ready), 64'd0);
        check("reset req_valid", 64'(bus.req_valid), 64'd0);
        check("reset inflight", 64'(inflight), 64'd0);
        check("reset finished", 64'(finished), 64'd0);
        check("reset cycle", bus.trace_read_cycle, 64'd0);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            set_line(tbl[i].tv, tbl[i].tf, BASE_A);
            bus.req_ready  = tbl[i].rr;
            bus.resp_valid = tbl[i].rsp;
            #1;
            $display("vec %0d: rdy=%0b cyc=%0d req_valid=%b inflight=%0d finished=%0b",
                     i, bus.trace_read_ready, bus.trace_read_cycle, bus.req_valid, inflight, finished);
            check($sformatf("vec%0d ready", i), 64'(bus.trace_read_ready), 64'(tbl[i].exp_rdy));
            check($sformatf("vec%0d cycle", i), bus.trace_read_cycle, 64'(tbl[i].exp_cyc));
            check($sformatf("vec%0d req_valid", i), 64'(bus.req_valid), 64'(tbl[i].exp_req));
            check($sformatf("vec%0d inflight", i), 64'(inflight), 64'(tbl[i].exp_infl));
            check($sformatf("vec%0d finished", i), 64'(finished), 64'(tbl[i].exp_fin));
            @(negedge clock);
        end

        // Backpressure: lanes 0,2 fire first, lanes 1,3 stall until ready opens.
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        do_reset();
        set_line('0, 1'b0, BASE_A);
        #1;
        $display("bp s0: rdy=%0b cyc=%0d", bus.trace_read_ready, bus.trace_read_cycle);
        check("bp fetch ready", 64'(bus.trace_read_ready), 64'd1);
        check("bp fetch cycle", bus.trace_read_cycle, 64'd0);
        @(negedge clock);
        set_line(4'b1111, 1'b0, BASE_A);
        #1;
        check("bp capture ready", 64'(bus.trace_read_ready), 64'd0);
        @(negedge clock);
        set_line(4'b1111, 1'b0, BASE_B);
        for (int s = 2; s <= 5; s++) begin
            bus.req_ready = (s == 5) ? 4'b1111 : 4'b0101;
            #1;
            $display("bp s%0d: req_valid=%b addr1=0x%0h addr3=0x%0h", s, bus.req_valid,
                     bus.req_address[DW*1 +: DW], bus.req_address[DW*3 +: DW]);
            check($sformatf("bp s%0d req_valid", s), 64'(bus.req_valid),
                  (s == 2) ? 64'hF : 64'hA);
            check($sformatf("bp s%0d addr1", s), bus.req_address[DW*1 +: DW], lane_addr(BASE_A, 1));
            check($sformatf("bp s%0d addr3", s), bus.req_address[DW*3 +: DW], lane_addr(BASE_A, 3));
            check($sformatf("bp s%0d data1", s), bus.req_data[DW*1 +: DW], ~lane_addr(BASE_A, 1));
            check($sformatf("bp s%0d data3", s), bus.req_data[DW*3 +: DW], ~lane_addr(BASE_A, 3));
            check($sformatf("bp s%0d size3", s), 64'(bus.req_size[SW*3 +: SW]), 64'd4);
            check($sformatf("bp s%0d store", s), 64'(bus.req_is_store), 64'hA);
            check($sformatf("bp s%0d ready", s), 64'(bus.trace_read_ready), 64'd0);
            check($sformatf("bp s%0d cycle", s), bus.trace_read_cycle, 64'd1);
            @(negedge clock);
        end
        bus.req_ready = '0;
        #1;
        $display("bp s6: rdy=%0b cyc=%0d inflight=%0d", bus.trace_read_ready, bus.trace_read_cycle, inflight);
        check("bp s6 ready", 64'(bus.trace_read_ready), 64'd1);
        check("bp s6 cycle", bus.trace_read_cycle, 64'd1);
        check("bp s6 req_valid", 64'(bus.req_valid), 64'd0);
        check("bp s6 inflight", 64'(inflight), 64'd4);
        @(negedge clock);

        // Reset in the middle of an ISSUE stall.
        set_line(4'b1111, 1'b0, BASE_B);
        bus.resp_valid = 4'b1111;
        #1;
        check("rs capture inflight", 64'(inflight), 64'd4);
        @(negedge clock);
        bus.resp_valid = '0;
        #1;
        check("rs issue req_valid", 64'(bus.req_valid), 64'hF);
        check("rs issue inflight", 64'(inflight), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        $display("rs asserted: req_valid=%b rdy=%0b cyc=%0d", bus.req_valid, bus.trace_read_ready, bus.trace_read_cycle);
        check("rs req_valid", 64'(bus.req_valid), 64'd0);
        check("rs ready", 64'(bus.trace_read_ready), 64'd0);
        check("rs cycle", bus.trace_read_cycle, 64'd0);
        check("rs addr0", bus.req_address[DW*0 +: DW], 64'd0);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("rs held ready", 64'(bus.trace_read_ready), 64'd0);
        check("rs held finished", 64'(finished), 64'd0);
        reset = 1'b1;
        #1;
        $display("rs released: rdy=%0b cyc=%0d inflight=%0d", bus.trace_read_ready, bus.trace_read_cycle, inflight);
        check("rs release ready", 64'(bus.trace_read_ready), 64'd1);
        check("rs release cycle", bus.trace_read_cycle, 64'd0);
        check("rs release req_valid", 64'(bus.req_valid), 64'd0);
        check("rs release inflight", 64'(inflight), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
